calc_result_display: RTL

//  Downstream stage of the calculator core. Captures each 16-bit unsigned magnitude RESULT + NEG sign,

---
 rtl/calc_disp_pkg.sv | 39 +++
 rtl/calc_result_display_if.sv | 40 ++++
 rtl/calc_bin2bcd.sv | 64 ++++++
 rtl/calc_result_display.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_disp_pkg.sv
// -----------------------------------------------------------------------------
// calc_disp_pkg
// Shared types and constants for the calculator result display slice:
//   - state_t      : conversion FSM states (IDLE -> SHIFT -> DONE -> IDLE)
//   - NUM_DIGITS   : digits on the multiplexed display (5 = sign, 4..0 = value)
//   - BCD_DIGITS   : BCD digits produced from a 16-bit magnitude
//   - SEG_FONT     : active-high 7-segment patterns {g,f,e,d,c,b,a} for 0-F
//   - SEG_DASH     : minus sign (segment g only)
//   - SEG_BLANK    : all segments off
//   - digit_to_seg : nibble -> active-high segment pattern
// -----------------------------------------------------------------------------
package calc_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 6;
    localparam int BCD_DIGITS = 5;
    localparam int RESULT_W   = 16;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;

    localparam logic [6:0] SEG_FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

    function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
        return SEG_FONT[digit];
    endfunction

endpackage

// File: rtl/calc_result_display_if.sv
// -----------------------------------------------------------------------------
// calc_result_display_if
// Result/BCD handshake between the calculator core and calc_result_display.
//   res_valid  : 1-cycle strobe, result/neg valid this cycle
//   result     : 16-bit unsigned magnitude
//   neg        : sign of result (1 = negative)
//   hex_mode   : (only with CALC_DISP_HEX_EN) bypass decimal conversion
//   busy       : conversion in progress
//   bcd_out    : 5 BCD digits, [19:16] = ten-thousands
//   bcd_neg    : sign belonging to bcd_out
//   bcd_valid  : 1-cycle pulse when bcd_out/bcd_neg update
// master = calculator core side, slave = display block side.
// -----------------------------------------------------------------------------
interface calc_result_display_if;
    import calc_disp_pkg::*;

    logic                res_valid;
    logic [RESULT_W-1:0] result;
    logic                neg;
`ifdef CALC_DISP_HEX_EN
    logic                hex_mode;
`endif
    logic                busy;
    logic [BCD_W-1:0]    bcd_out;
    logic                bcd_neg;
    logic                bcd_valid;

`ifdef CALC_DISP_HEX_EN
    modport master (output res_valid, result, neg, hex_mode,
                    input  busy, bcd_out, bcd_neg, bcd_valid);
    modport slave  (input  res_valid, result, neg, hex_mode,
                    output busy, bcd_out, bcd_neg, bcd_valid);
`else
    modport master (output res_valid, result, neg,
                    input  busy, bcd_out, bcd_neg, bcd_valid);
    modport slave  (input  res_valid, result, neg,
                    output busy, bcd_out, bcd_neg, bcd_valid);
`endif

endinterface

// File: rtl/calc_bin2bcd.sv
// -----------------------------------------------------------------------------
// calc_bin2bcd
// Sequential double-dabble: one add-3-then-shift step per clock, 16 steps.
//   clk, reset : clock, asynchronous active-high reset
//   start      : load bin and begin conversion (ignored while converting)
//   bin        : 16-bit binary input
//   done       : high during the final step; bcd is the finished result then
//   bcd        : 5-digit BCD result (valid while done=1)
// The result is presented combinationally during the last step so the caller
// can register it on the same edge that ends the conversion.
// -----------------------------------------------------------------------------
module calc_bin2bcd
    import calc_disp_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [RESULT_W-1:0] bin,
    output logic                done,
    output logic [BCD_W-1:0]    bcd
);

    localparam int SH_W = BCD_W + RESULT_W;

    logic [SH_W-1:0] sh_q;
    logic [SH_W-1:0] sh_next;
    logic [3:0]      cnt_q;
    logic            active_q;

    // Adjust every BCD digit >= 5 by +3, then shift the whole register left.
    function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] v);
        logic [SH_W-1:0] t;
        t = v;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (t[RESULT_W + 4*d +: 4] >= 4'd5)
                t[RESULT_W + 4*d +: 4] = t[RESULT_W + 4*d +: 4] + 4'd3;
        end
        return {t[SH_W-2:0], 1'b0};
    endfunction

    assign sh_next = dd_step(sh_q);
    assign done    = active_q && (cnt_q == 4'd15);
    assign bcd     = sh_next[SH_W-1:RESULT_W];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q     <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start && !active_q) begin
            sh_q     <= {{BCD_W{1'b0}}, bin};
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            sh_q  <= sh_next;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15)
                active_q <= 1'b0;
        end
    end

endmodule

// File: rtl/calc_result_display.sv
// -----------------------------------------------------------------------------
// calc_result_display
// Captures a 16-bit magnitude + sign, converts it to 5-digit BCD and drives a
// 6-digit multiplexed 7-segment display (digit 5 = sign, digits 4..0 = value).
//   clk, reset : clock, asynchronous active-high reset
//   bus        : calc_result_display_if.slave (result in, BCD word out)
//   seg        : segments {g,f,e,d,c,b,a}
//   an         : one-hot digit enables
// Parameters:
//   REFRESH_DIV    : clk cycles each digit stays enabled (>= 2)
//   SEG_ACTIVE_LOW : 1 = seg/an low means lit/enabled
// Optional build macro CALC_DISP_HEX_EN adds bus.hex_mode: a capture with
// hex_mode=1 skips conversion and shows the raw value as 4 hex digits.
// A result arriving while a conversion is in flight (or in the DONE cycle)
// is parked in a 1-deep pending slot; the newest one wins.
// -----------------------------------------------------------------------------
module calc_result_display #(
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    calc_result_display_if.slave       bus,
    output logic [6:0]                 seg,
    output logic [5:0]                 an
);
    import calc_disp_pkg::*;

    localparam int               DIV_W    = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    state_t              state_q, state_d;

    logic                pend_valid_q;
    logic [RESULT_W-1:0] pend_result_q;
    logic                pend_neg_q;
`ifdef CALC_DISP_HEX_EN
    logic                pend_hex_q;
`endif

    logic                cap_neg_q;
    logic [BCD_W-1:0]    bcd_q;
    logic                bcd_neg_q;
    logic                disp_hex_q;

    logic                take_input, take_pend, capture;
    logic [RESULT_W-1:0] src_result;
    logic                src_neg, src_hex;

    logic                conv_done;
    logic [BCD_W-1:0]    conv_bcd;

    logic [DIV_W-1:0]    div_q;
    logic [2:0]          scan_idx_q;
    logic [6:0]          glyph;
    logic [3:0]          nib;
    logic [4:0]          base;
    logic [5:0]          an_onehot;
    logic [6:0]          seg_q;
    logic [5:0]          an_q;

    // ---------------- capture source selection ----------------
    // A parked result has priority over a fresh strobe in IDLE; the fresh one
    // then takes the pending slot instead of being lost.
    assign take_input = (state_q == ST_IDLE) && !pend_valid_q && bus.res_valid;
    assign take_pend  = (state_q == ST_IDLE) && pend_valid_q;
    assign capture    = take_input || take_pend;

    always_comb begin
        src_result = pend_valid_q ? pend_result_q : bus.result;
        src_neg    = pend_valid_q ? pend_neg_q    : bus.neg;
`ifdef CALC_DISP_HEX_EN
        src_hex    = pend_valid_q ? pend_hex_q    : bus.hex_mode;
`else
        src_hex    = 1'b0;
`endif
    end

    calc_bin2bcd u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (capture && !src_hex),
        .bin   (src_result),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (capture)   state_d = src_hex ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (conv_done) state_d = ST_DONE;
            ST_DONE:                 state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // ---------------- capture, pending slot, result registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid_q  <= 1'b0;
            pend_result_q <= '0;
            pend_neg_q    <= 1'b0;
`ifdef CALC_DISP_HEX_EN
            pend_hex_q    <= 1'b0;
`endif
            cap_neg_q     <= 1'b0;
            bcd_q         <= '0;
            bcd_neg_q     <= 1'b0;
            disp_hex_q    <= 1'b0;
        end else begin
            if (bus.res_valid && !take_input) begin
                pend_valid_q  <= 1'b1;
                pend_result_q <= bus.result;
                pend_neg_q    <= bus.neg;
`ifdef CALC_DISP_HEX_EN
                pend_hex_q    <= bus.hex_mode;
`endif
            end else if (take_pend) begin
                pend_valid_q  <= 1'b0;
            end

            if (capture)
                cap_neg_q <= src_neg;

            // Result registers load on the edge that enters DONE.
            if (capture && src_hex) begin
                bcd_q      <= {4'h0, src_result};
                bcd_neg_q  <= src_neg;
                disp_hex_q <= 1'b1;
            end else if ((state_q == ST_SHIFT) && conv_done) begin
                bcd_q      <= conv_bcd;
                bcd_neg_q  <= cap_neg_q;
                disp_hex_q <= 1'b0;
            end
        end
    end

    assign bus.busy      = (state_q == ST_SHIFT);
    assign bus.bcd_valid = (state_q == ST_DONE);
    assign bus.bcd_out   = bcd_q;
    assign bus.bcd_neg   = bcd_neg_q;

    // ---------------- display scan ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q      <= '0;
            scan_idx_q <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q      <= '0;
            scan_idx_q <= (scan_idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : scan_idx_q + 3'd1;
        end else begin
            div_q      <= div_q + 1'b1;
        end
    end

    // Glyph for the digit currently scanned. Decimal: blank a value digit when
    // it and every digit above it are zero (digit 0 is always shown). The dash
    // is suppressed for a zero value so negative zero reads as "0".
    always_comb begin
        glyph     = SEG_BLANK;
        nib       = 4'h0;
        base      = {scan_idx_q[2:0], 2'b00};
        an_onehot = 6'b000001 << scan_idx_q;
        if (scan_idx_q == 3'd5) begin
            if (disp_hex_q ? bcd_neg_q : (bcd_neg_q && (bcd_q != '0)))
                glyph = SEG_DASH;
        end else begin
            nib = bcd_q[base +: 4];
            if (disp_hex_q) begin
                if (scan_idx_q != 3'd4)
                    glyph = digit_to_seg(nib);
            end else if ((scan_idx_q == 3'd0) || ((bcd_q >> base) != '0)) begin
                glyph = digit_to_seg(nib);
            end
        end
    end

    // Registered outputs: inactive during the first clock after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q <= {7{SEG_ACTIVE_LOW}};
            an_q  <= {6{SEG_ACTIVE_LOW}};
        end else begin
            seg_q <= SEG_ACTIVE_LOW ? ~glyph     : glyph;
            an_q  <= SEG_ACTIVE_LOW ? ~an_onehot : an_onehot;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule
